// File: rtl/ahb_pkg.sv
// Shared AHB-Lite constants and the data-phase state type for the slave select controller.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam int unsigned SEL_W = 3;
  localparam logic [SEL_W-1:0] SEL_DEFAULT = 3'b100;
  localparam logic [SEL_W-1:0] SEL_NONE    = 3'b111;

  typedef enum logic [1:0] {
    ST_NONE = 2'd0,
    ST_SLV  = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } dphase_state_e;

endpackage

// File: rtl/ahb_addr_decoder.sv
// Combinational address decoder: priority one-hot slave select plus 3-bit decode code.
module ahb_addr_decoder
  import ahb_pkg::*;
#(
  parameter logic [31:0] S0_BASE  = 32'h0000_0000,
  parameter logic [31:0] S1_BASE  = 32'h1000_0000,
  parameter logic [31:0] S2_BASE  = 32'h2000_0000,
  parameter logic [31:0] S3_BASE  = 32'h3000_0000,
  parameter logic [31:0] DEC_MASK = 32'hF000_0000
) (
  input  logic [31:0]      i_haddr,
  output logic [3:0]       o_hsel_c,
  output logic [SEL_W-1:0] o_code_c
);

  logic [3:0] w_match;

  assign w_match[0] = ((i_haddr & DEC_MASK) == (S0_BASE & DEC_MASK));
  assign w_match[1] = ((i_haddr & DEC_MASK) == (S1_BASE & DEC_MASK));
  assign w_match[2] = ((i_haddr & DEC_MASK) == (S2_BASE & DEC_MASK));
  assign w_match[3] = ((i_haddr & DEC_MASK) == (S3_BASE & DEC_MASK));

  // Lowest slave index wins when base regions overlap
  always_comb begin
    o_hsel_c = 4'b0000;
    o_code_c = SEL_DEFAULT;
    if (w_match[0]) begin
      o_hsel_c = 4'b0001;
      o_code_c = 3'b000;
    end else if (w_match[1]) begin
      o_hsel_c = 4'b0010;
      o_code_c = 3'b001;
    end else if (w_match[2]) begin
      o_hsel_c = 4'b0100;
      o_code_c = 3'b010;
    end else if (w_match[3]) begin
      o_hsel_c = 4'b1000;
      o_code_c = 3'b011;
    end
  end

endmodule

// File: rtl/ahb_slave_sel_ctrl.sv
// AHB-Lite 4-slave decoder and data-phase sequencer with default ERROR slave.
// Optional wait-state watchdog enabled by defining AHB_TIMEOUT_EN.
module ahb_slave_sel_ctrl
  import ahb_pkg::*;
#(
  parameter logic [31:0] S0_BASE  = 32'h0000_0000,
  parameter logic [31:0] S1_BASE  = 32'h1000_0000,
  parameter logic [31:0] S2_BASE  = 32'h2000_0000,
  parameter logic [31:0] S3_BASE  = 32'h3000_0000,
  parameter logic [31:0] DEC_MASK = 32'hF000_0000
`ifdef AHB_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 16
`endif
) (
  input  logic             hclk,
  input  logic             hreset,
  input  logic [31:0]      haddr,
  input  logic [1:0]       htrans,
  input  logic [3:0]       hreadyout_s,
  input  logic [3:0]       hresp_s,
  output logic [3:0]       hsel,
  output logic [SEL_W-1:0] sel,
  output logic             hready,
  output logic             hresp,
  output logic             timeout_irq
);

  logic [3:0]       w_hsel;
  logic [SEL_W-1:0] w_dec_code;
  logic             w_active;
  logic             w_hready;
  logic             w_hresp;
  logic             w_expire;
  logic [SEL_W-1:0] r_sel;
  logic [SEL_W-1:0] w_sel_nxt;
  dphase_state_e    r_state;
  dphase_state_e    w_state_nxt;

  ahb_addr_decoder #(
    .S0_BASE  (S0_BASE),
    .S1_BASE  (S1_BASE),
    .S2_BASE  (S2_BASE),
    .S3_BASE  (S3_BASE),
    .DEC_MASK (DEC_MASK)
  ) u_addr_decoder (
    .i_haddr  (haddr),
    .o_hsel_c (w_hsel),
    .o_code_c (w_dec_code)
  );

  always_comb begin
    w_active = 1'b0;
    case (htrans)
      HTRANS_NONSEQ, HTRANS_SEQ: w_active = 1'b1;
      HTRANS_IDLE, HTRANS_BUSY:  w_active = 1'b0;
    endcase
  end

  // Response mux back to the master
  always_comb begin
    w_hready = 1'b1;
    w_hresp  = HRESP_OKAY;
    case (r_state)
      ST_SLV: begin
        w_hready = hreadyout_s[r_sel[1:0]];
        w_hresp  = hresp_s[r_sel[1:0]];
      end
      ST_ERR1: begin
        w_hready = 1'b0;
        w_hresp  = HRESP_ERROR;
      end
      ST_ERR2: begin
        w_hready = 1'b1;
        w_hresp  = HRESP_ERROR;
      end
      default: ;
    endcase
  end

  // Watchdog abort beats everything; otherwise capture only when the bus is ready
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    if (w_expire) begin
      w_state_nxt = ST_ERR1;
    end else if (r_state == ST_ERR1) begin
      w_state_nxt = ST_ERR2;
    end else if (w_hready) begin
      if (!w_active) begin
        w_state_nxt = ST_NONE;
        w_sel_nxt   = SEL_NONE;
      end else if (w_dec_code == SEL_DEFAULT) begin
        w_state_nxt = ST_ERR1;
        w_sel_nxt   = SEL_DEFAULT;
      end else begin
        w_state_nxt = ST_SLV;
        w_sel_nxt   = w_dec_code;
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_state <= ST_NONE;
      r_sel   <= SEL_NONE;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
    end
  end

`ifdef AHB_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] r_wait_cnt;
  logic       r_irq;
  logic       w_waiting;

  assign w_waiting = (r_state == ST_SLV) && !hreadyout_s[r_sel[1:0]];
  assign w_expire  = w_waiting && (r_wait_cnt == TO_LAST);

  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_wait_cnt <= 8'd0;
      r_irq      <= 1'b0;
    end else begin
      r_irq      <= w_expire;
      r_wait_cnt <= (w_waiting && !w_expire) ? r_wait_cnt + 8'd1 : 8'd0;
    end
  end

  assign timeout_irq = r_irq;
`else
  assign w_expire    = 1'b0;
  assign timeout_irq = 1'b0;
`endif

  assign hsel   = w_hsel;
  assign sel    = r_sel;
  assign hready = w_hready;
  assign hresp  = w_hresp;

endmodule

// File: tb/tb_ahb_slave_sel_ctrl.sv
// Scoreboard bench for ahb_slave_sel_ctrl; timeout scenarios build only with AHB_TIMEOUT_EN.
module tb_ahb_slave_sel_ctrl;

  typedef struct packed {
    logic [2:0] sel;
    logic       hready;
    logic       hresp;
    logic       irq;
    logic [3:0] hsel;
  } obs_t;

  logic        hclk = 1'b0;
  logic        hreset;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic [3:0]  hreadyout_s;
  logic [3:0]  hresp_s;
  logic [3:0]  hsel;
  logic [2:0]  sel;
  logic        hready;
  logic        hresp;
  logic        timeout_irq;

  int n_checks = 0;
  int n_errors = 0;
  obs_t sb_q[$];
  obs_t ob_q[$];

  localparam logic [1:0] IDLE = 2'b00, NSEQ = 2'b10, SEQ = 2'b11;

  ahb_slave_sel_ctrl #(
    .S0_BASE  (32'h0000_0000),
    .S1_BASE  (32'h1000_0000),
    .S2_BASE  (32'h2000_0000),
    .S3_BASE  (32'h3000_0000),
    .DEC_MASK (32'hF000_0000)
`ifdef AHB_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES (4)
`endif
  ) dut (
    .hclk        (hclk),
    .hreset      (hreset),
    .haddr       (haddr),
    .htrans      (htrans),
    .hreadyout_s (hreadyout_s),
    .hresp_s     (hresp_s),
    .hsel        (hsel),
    .sel         (sel),
    .hready      (hready),
    .hresp       (hresp),
    .timeout_irq (timeout_irq)
  );

  always #5 hclk = ~hclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  function automatic logic [3:0] model_hsel(input logic [31:0] a);
    case (a[31:28])
      4'h0:    return 4'b0001;
      4'h1:    return 4'b0010;
      4'h2:    return 4'b0100;
      4'h3:    return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  // One bus cycle: drive inputs, push the expected view, record the DUT view mid-cycle
  task automatic apply(input logic rst, input logic [31:0] a, input logic [1:0] t,
                       input logic [3:0] rdy, input logic [3:0] rsp,
                       input logic [2:0] esel, input logic erdy, input logic eresp,
                       input logic eirq);
    @(posedge hclk);
    #1;
    hreset = rst; haddr = a; htrans = t; hreadyout_s = rdy; hresp_s = rsp;
    sb_q.push_back('{sel: esel, hready: erdy, hresp: eresp, irq: eirq, hsel: model_hsel(a)});
    @(negedge hclk);
    ob_q.push_back('{sel: sel, hready: hready, hresp: hresp, irq: timeout_irq, hsel: hsel});
  endtask

  task automatic test_reset();
    obs_t e, o;
    apply(1, 32'h2000_0040, IDLE, 4'hF, 4'h0, 3'b111, 1, 0, 0);
    apply(1, 32'h8000_0000, NSEQ, 4'hF, 4'h0, 3'b111, 1, 0, 0);
    apply(0, 32'h1000_0004, IDLE, 4'hF, 4'h0, 3'b111, 1, 0, 0);
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front(); o = ob_q.pop_front(); n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL reset: got %b want %b", o, e); end
    end
  endtask

  task automatic test_mapped();
    obs_t e, o;
    apply(0, 32'h2000_0040, NSEQ, 4'hF, 4'h0, 3'b111, 1, 0, 0);
    apply(0, 32'h1000_0000, SEQ,  4'hF, 4'h0, 3'b010, 1, 0, 0);
    apply(0, 32'h0000_0000, IDLE, 4'hF, 4'h0, 3'b001, 1, 0, 0);
    apply(0, 32'h0000_0000, IDLE, 4'hF, 4'h0, 3'b111, 1, 0, 0);
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front(); o = ob_q.pop_front(); n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL mapped: got %b want %b", o, e); end
    end
  endtask

  task automatic test_wait_states();
    obs_t e, o;
    apply(0, 32'h3000_0000, NSEQ, 4'hF, 4'h0, 3'b111, 1, 0, 0);
    for (int i = 0; i < 3; i++)
      apply(0, 32'h1000_0000, NSEQ, 4'b0111, 4'h0, 3'b011, 0, 0, 0);
    apply(0, 32'h1000_0000, NSEQ, 4'hF, 4'h0, 3'b011, 1, 0, 0);
    apply(0, 32'h0000_0000, IDLE, 4'hF, 4'h0, 3'b001, 1, 0, 0);
    apply(0, 32'h0000_0000, IDLE, 4'hF, 4'h0, 3'b111, 1, 0, 0);
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front(); o = ob_q.pop_front(); n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL wait_states: got %b want %b", o, e); end
    end
  endtask

  task automatic test_slave_error();
    obs_t e, o;
    apply(0, 32'h2000_0000, NSEQ, 4'hF,    4'h0,    3'b111, 1, 0, 0);
    apply(0, 32'h2000_0000, IDLE, 4'b1011, 4'b0100, 3'b010, 0, 1, 0);
    apply(0, 32'h2000_0000, IDLE, 4'hF,    4'b0100, 3'b010, 1, 1, 0);
    apply(0, 32'h2000_0000, IDLE, 4'hF,    4'h0,    3'b111, 1, 0, 0);
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front(); o = ob_q.pop_front(); n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL slave_error: got %b want %b", o, e); end
    end
  endtask

  task automatic test_unmapped();
    obs_t e, o;
    apply(0, 32'h8000_0000, NSEQ, 4'hF, 4'h0, 3'b111, 1, 0, 0);
    apply(0, 32'h8000_0000, IDLE, 4'hF, 4'h0, 3'b100, 0, 1, 0);
    apply(0, 32'h8000_0000, IDLE, 4'hF, 4'h0, 3'b100, 1, 1, 0);
    apply(0, 32'h8000_0000, IDLE, 4'hF, 4'h0, 3'b111, 1, 0, 0);
    apply(0, 32'h8000_0000, IDLE, 4'hF, 4'h0, 3'b111, 1, 0, 0);
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front(); o = ob_q.pop_front(); n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL unmapped: got %b want %b", o, e); end
    end
  endtask

  task automatic test_back_to_back();
    obs_t e, o;
    apply(0, 32'h8000_0000, NSEQ, 4'hF, 4'h0, 3'b111, 1, 0, 0);
    apply(0, 32'h9000_0000, NSEQ, 4'hF, 4'h0, 3'b100, 0, 1, 0);
    apply(0, 32'h9000_0000, NSEQ, 4'hF, 4'h0, 3'b100, 1, 1, 0);
    apply(0, 32'h0000_0000, IDLE, 4'hF, 4'h0, 3'b100, 0, 1, 0);
    apply(0, 32'h0000_0000, IDLE, 4'hF, 4'h0, 3'b100, 1, 1, 0);
    apply(0, 32'h0000_0000, IDLE, 4'hF, 4'h0, 3'b111, 1, 0, 0);
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front(); o = ob_q.pop_front(); n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL back_to_back: got %b want %b", o, e); end
    end
  endtask

  task automatic test_reset_in_err1();
    obs_t e, o;
    apply(0, 32'hA000_0000, NSEQ, 4'hF, 4'h0, 3'b111, 1, 0, 0);
    apply(1, 32'hA000_0000, IDLE, 4'hF, 4'h0, 3'b100, 0, 1, 0);
    apply(0, 32'hA000_0000, IDLE, 4'hF, 4'h0, 3'b111, 1, 0, 0);
    apply(0, 32'hA000_0000, IDLE, 4'hF, 4'h0, 3'b111, 1, 0, 0);
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front(); o = ob_q.pop_front(); n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL reset_in_err1: got %b want %b", o, e); end
    end
  endtask

`ifdef AHB_TIMEOUT_EN
  task automatic test_timeout();
    obs_t e, o;
    apply(0, 32'h0000_0100, NSEQ, 4'hF, 4'h0, 3'b111, 1, 0, 0);
    for (int i = 0; i < 4; i++)
      apply(0, 32'h0000_0000, IDLE, 4'b1110, 4'h0, 3'b000, 0, 0, 0);
    apply(0, 32'h0000_0000, IDLE, 4'b1110, 4'h0, 3'b000, 0, 1, 1);
    apply(0, 32'h0000_0000, IDLE, 4'b1110, 4'h0, 3'b000, 1, 1, 0);
    apply(0, 32'h0000_0000, IDLE, 4'hF,    4'h0, 3'b111, 1, 0, 0);
    // ready on the expiry cycle must win
    apply(0, 32'h0000_0100, NSEQ, 4'hF, 4'h0, 3'b111, 1, 0, 0);
    for (int i = 0; i < 3; i++)
      apply(0, 32'h0000_0000, IDLE, 4'b1110, 4'h0, 3'b000, 0, 0, 0);
    apply(0, 32'h0000_0000, IDLE, 4'hF, 4'h0, 3'b000, 1, 0, 0);
    apply(0, 32'h0000_0000, IDLE, 4'hF, 4'h0, 3'b111, 1, 0, 0);
    apply(0, 32'h0000_0000, IDLE, 4'hF, 4'h0, 3'b111, 1, 0, 0);
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front(); o = ob_q.pop_front(); n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL timeout: got %b want %b", o, e); end
    end
  endtask
`else
  task automatic test_no_timeout();
    obs_t e, o;
    apply(0, 32'h0000_0100, NSEQ, 4'hF, 4'h0, 3'b111, 1, 0, 0);
    for (int i = 0; i < 20; i++)
      apply(0, 32'h0000_0000, IDLE, 4'b1110, 4'h0, 3'b000, 0, 0, 0);
    apply(0, 32'h0000_0000, IDLE, 4'hF, 4'h0, 3'b000, 1, 0, 0);
    apply(0, 32'h0000_0000, IDLE, 4'hF, 4'h0, 3'b111, 1, 0, 0);
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front(); o = ob_q.pop_front(); n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL no_timeout: got %b want %b", o, e); end
    end
  endtask
`endif

  initial begin
    hreset = 1'b1; haddr = '0; htrans = IDLE; hreadyout_s = 4'hF; hresp_s = 4'h0;
    repeat (2) @(posedge hclk);
    test_reset();
    test_mapped();
    test_wait_states();
    test_slave_error();
    test_unmapped();
    test_back_to_back();
    test_reset_in_err1();
`ifdef AHB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
